onehot_decoder: RTL and testbench

Buffered 4-bit code to 16-bit one-hot decoder: the inverse of the team's 16-to-4 one-hot encoder. It takes 4-bit codes in over a valid/ready stream and produces the matching one-hot words on an output valid/ready stream. A small FIFO absorbs downstream backpressure, and a saturating counter tracks how many zero (no-line) codes have been decoded. It sits on the return path wherever an encoded line index must be expanded back into a one-hot select.

---
 rtl/onehot_decoder.sv | 131 +++++++++++++
 tb/tb_onehot_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder.sv
// onehot_decoder: buffered 4-bit code to 16-bit one-hot decoder.
//
// Codes arrive on a valid/ready input stream. Each code is decoded when it is
// loaded into the output register: 0 -> 16'h0000, k -> 16'h0001 << (k-1).
// A FIFO of DEPTH raw codes sits in front of the output register. The FIFO
// absorbs downstream backpressure, so total capacity is DEPTH+1 codes.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - in_code is presented
//   in_ready   - a code can be accepted (FIFO count < DEPTH)
//   in_code    - 4-bit code to decode
//   out_valid  - out_onehot / out_zero hold a decoded word
//   out_ready  - downstream accepts the word
//   out_onehot - decoded one-hot word (bit 15 never set)
//   out_zero   - decoded code was 0
//   zero_cnt   - saturating count of zero words delivered downstream
module onehot_decoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_onehot,
    output logic        out_zero,
    output logic [7:0]  zero_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    function automatic logic [15:0] decode(input logic [3:0] code);
        logic [15:0] word;
        word = '0;
        if (code != 4'd0) begin
            word = 16'h0001 << (code - 4'd1);
        end
        return word;
    endfunction

    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_onehot_q, out_onehot_d;
    logic          out_zero_q, out_zero_d;
    logic [7:0]    zero_cnt_q, zero_cnt_d;

    logic          accept, deliver, out_free, fifo_empty;
    logic          push, pop, load;
    logic [3:0]    load_code;

    // Registered count only, so no combinational path from out_ready.
    assign in_ready   = (count_q < CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign deliver    = out_valid_q && out_ready;
    assign out_free   = !out_valid_q || deliver;
    assign fifo_empty = (count_q == '0);

    always_comb begin
        pop       = out_free && !fifo_empty;
        // Bypass only when the FIFO is empty and the output register frees up.
        push      = accept && !(out_free && fifo_empty);
        load      = pop || (out_free && fifo_empty && accept);
        load_code = pop ? mem_q[rd_ptr_q] : in_code;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_zero_d   = out_zero_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_onehot_d = decode(load_code);
            out_zero_d   = (load_code == 4'd0);
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end

        zero_cnt_d = zero_cnt_q;
        if (deliver && out_zero_q && (zero_cnt_q != 8'hFF)) begin
            zero_cnt_d = zero_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_zero_q   <= 1'b0;
            zero_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_zero_q   <= out_zero_d;
            zero_cnt_q   <= zero_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_zero   = out_zero_q;
    assign zero_cnt   = zero_cnt_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder (DEPTH=4): reset values, in-order decode,
// capacity and backpressure, stall stability, zero counter saturation and
// mid-transfer reset.
module tb_onehot_decoder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_onehot;
    logic        out_zero;
    logic [7:0]  zero_cnt;

    int errors = 0;
    int checks = 0;

    onehot_decoder #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_zero   (out_zero),
        .zero_cnt   (zero_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_of(input logic [3:0] c);
        logic [15:0] w;
        w = '0;
        if (c != 4'd0) w = 16'h0001 << (c - 4'd1);
        return w;
    endfunction

    logic [15:0] exp2 [6];
    logic [3:0]  codes2 [6];
    logic [3:0]  sb [$];
    logic [3:0]  exp_code;
    logic [15:0] held;
    logic        acc;
    logic        stalled;
    int          n;

    initial begin
        codes2 = '{4'd7, 4'd3, 4'd12, 4'd0, 4'd9, 4'd5};
        exp2   = '{16'h0040, 16'h0004, 16'h0800, 16'h0000, 16'h0100, 16'h0010};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; in_code = 4'd0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_onehot", 32'(out_onehot), 32'h0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_zero_cnt", 32'(zero_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Codes 0..15 back to back with out_ready=1
        out_ready = 1'b1; in_valid = 1'b1; in_code = 4'd0;
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_word", 32'(out_onehot), 32'(word_of(4'(k))));
            check("t1_zero", 32'(out_zero), 32'(k == 0));
            if (k < 15) in_code = 4'(k + 1);
            else in_valid = 1'b0;
        end
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);
        check("t1_zero_cnt", 32'(zero_cnt), 32'd1);

        // Capacity with out_ready=0: five accepted, sixth held off
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_code  = codes2[i];
            check("t2_in_ready", 32'(in_ready), 32'(i < 5));
            if (i < 5) tick();
        end
        repeat (2) begin
            tick();
            check("t2_full_ready", 32'(in_ready), 32'd0);
            check("t2_hold_word", 32'(out_onehot), 32'h0040);
        end
        out_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 6; cyc++) begin
            acc = in_valid && in_ready;
            if (cyc == 0) check("t2_pop_edge_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                check("t2_word", 32'(out_onehot), 32'(exp2[n]));
                check("t2_zero", 32'(out_zero), 32'(n == 3));
                n++;
            end
            tick();
            if (cyc == 0) check("t2_ready_after_pop", 32'(in_ready), 32'd1);
            if (acc) in_valid = 1'b0;
        end
        check("t2_delivered", 32'(n), 32'd6);
        check("t2_zero_cnt", 32'(zero_cnt), 32'd2);

        // Toggle out_ready each cycle with incrementing codes
        in_valid = 1'b1; in_code = 4'd1; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = cyc[0];
            if (stalled) begin
                check("t3_stall_valid", 32'(out_valid), 32'd1);
                check("t3_stall_word", 32'(out_onehot), 32'(held));
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("t3_spurious", 32'd1, 32'd0);
                end else begin
                    exp_code = sb.pop_front();
                    check("t3_word", 32'(out_onehot), 32'(word_of(exp_code)));
                end
            end
            if (acc) sb.push_back(in_code);
            check("t3_occupancy_le5", 32'(sb.size() <= 5), 32'd1);
            stalled = out_valid && !out_ready;
            held    = out_onehot;
            tick();
            if (acc) in_code = in_code + 4'd1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
            if (out_valid) begin
                exp_code = sb.pop_front();
                check("t3_drain_word", 32'(out_onehot), 32'(word_of(exp_code)));
            end
            tick();
        end
        check("t3_all_delivered", 32'(sb.size()), 32'd0);
        check("t3_idle", 32'(out_valid), 32'd0);

        // 300 zero codes saturate zero_cnt
        in_valid = 1'b1; in_code = 4'd0;
        repeat (300) tick();
        check("t4_sat_running", 32'(zero_cnt), 32'hFF);
        in_valid = 1'b0;
        repeat (2) tick();
        check("t4_sat_final", 32'(zero_cnt), 32'hFF);

        // Fill with three codes, reset for a half cycle mid-transfer
        out_ready = 1'b0; in_valid = 1'b1;
        in_code = 4'd2; tick();
        in_code = 4'd4; tick();
        in_code = 4'd6; tick();
        in_valid = 1'b0;
        check("t5_filled_valid", 32'(out_valid), 32'd1);
        check("t5_filled_word", 32'(out_onehot), 32'h0002);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_onehot", 32'(out_onehot), 32'h0);
        check("t5_rst_zero_cnt", 32'(zero_cnt), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        #4;
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_code = 4'd1;
        tick();
        check("t5_after_valid", 32'(out_valid), 32'd1);
        check("t5_after_word", 32'(out_onehot), 32'h0001);
        check("t5_after_zero", 32'(out_zero), 32'd0);
        in_valid = 1'b0;
        tick();
        check("t5_no_stale", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
